// File: rtl/logic_cell_pipe.sv
`timescale 1ns/10ps
// -----------------------------------------------------------------------------
// logic_cell_pipe
//
// Purpose:
//   This is a registered, WIDTH-bit logic element. Each accepted operand set
//   gets one of eight bitwise operations, chosen per transaction. The result
//   and its zero and parity flags go into a 2-entry output queue. Both sides of
//   the queue use valid/ready handshakes.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        synchronous, active-high reset
//   in_valid   operand set valid
//   in_ready   an operand set can be accepted this cycle (registered count)
//   op         operation select:
//              0 AND, 1 NAND, 2 OR, 3 XOR, 4 MUX, 5 MUXI, 6 NOR, 7 XNOR
//   a, b       operands
//   s          per-bit select, used by MUX/MUXI only
//   out_valid  the head-of-queue result is valid
//   out_ready  the consumer takes the head result
//   y          head result
//   zero       head result is all zeros
//   parity     XOR-reduction of the head result
//   txn_count  accepted operand sets, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module logic_cell_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             parity,
  output logic [CNT_W-1:0] txn_count
);

  // A queue entry packs {parity, zero, result}.
  localparam int EW = WIDTH + 2;

  logic [WIDTH-1:0] w_result;
  logic             w_zero;
  logic             w_parity;
  logic [EW-1:0]    w_entry;
  logic [EW-1:0]    w_head;
  logic             w_accept;
  logic             w_pop;

  logic [EW-1:0]    r_mem [0:1];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic [CNT_W-1:0] r_txn_count;

  // Per-bit logic cell. Every op is legal, so there is no error path.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic w_mux;
      logic w_bit;

      assign w_mux = s[gi] ? b[gi] : a[gi];

      always_comb begin
        w_bit = 1'b0;
        case (op)
          3'd0:    w_bit =   a[gi] & b[gi];
          3'd1:    w_bit = ~(a[gi] & b[gi]);
          3'd2:    w_bit =   a[gi] | b[gi];
          3'd3:    w_bit =   a[gi] ^ b[gi];
          3'd4:    w_bit =   w_mux;
          3'd5:    w_bit =  ~w_mux;
          3'd6:    w_bit = ~(a[gi] | b[gi]);
          default: w_bit = ~(a[gi] ^ b[gi]);
        endcase
      end

      assign w_result[gi] = w_bit;
    end
  endgenerate

  assign w_zero   = ~|w_result;
  assign w_parity = ^w_result;
  assign w_entry  = {w_parity, w_zero, w_result};

  // in_ready comes only from the registered count. This keeps out_ready off
  // any combinational path to the upstream side.
  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);

  assign w_accept = in_valid & in_ready;
  assign w_pop    = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0]    <= '0;
      r_mem[1]    <= '0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_count     <= 2'd0;
      r_txn_count <= '0;
    end else begin
      if (w_accept) begin
        r_mem[r_wr_ptr] <= w_entry;
        r_wr_ptr        <= ~r_wr_ptr;
        r_txn_count     <= r_txn_count + CNT_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      // A push and a pop in the same cycle leave the occupancy unchanged.
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // The head entry drives the outputs directly. After a reset the head is
  // cleared to zero; after the queue drains it keeps the last popped value.
  assign w_head    = r_mem[r_rd_ptr];
  assign y         = w_head[WIDTH-1:0];
  assign zero      = w_head[WIDTH];
  assign parity    = w_head[WIDTH+1];
  assign txn_count = r_txn_count;

endmodule

// File: tb/tb_logic_cell_pipe.sv
`timescale 1ns/10ps
module tb_logic_cell_pipe;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] s;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             zero;
  logic             parity;
  logic [CNT_W-1:0] txn_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  logic_cell_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .s         (s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .zero      (zero),
    .parity    (parity),
    .txn_count (txn_count)
  );

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic [7:0] y;
    logic       z;
    logic       p;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one edge, then settle 1ns so outputs are sampled away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [7:0] xa,
                       input logic [7:0] xb, input logic [7:0] xs);
    in_valid = v;
    op       = o;
    a        = xa;
    b        = xb;
    s        = xs;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Sweep of all ops with a=AA, b=0F, s=F0, then extra vectors with odd parity
    // and zero results.
    vecs[0]  = '{3'd0, 8'hAA, 8'h0F, 8'hF0, 8'h0A, 1'b0, 1'b0};
    vecs[1]  = '{3'd1, 8'hAA, 8'h0F, 8'hF0, 8'hF5, 1'b0, 1'b0};
    vecs[2]  = '{3'd2, 8'hAA, 8'h0F, 8'hF0, 8'hAF, 1'b0, 1'b0};
    vecs[3]  = '{3'd3, 8'hAA, 8'h0F, 8'hF0, 8'hA5, 1'b0, 1'b0};
    vecs[4]  = '{3'd4, 8'hAA, 8'h0F, 8'hF0, 8'h0A, 1'b0, 1'b0};
    vecs[5]  = '{3'd5, 8'hAA, 8'h0F, 8'hF0, 8'hF5, 1'b0, 1'b0};
    vecs[6]  = '{3'd6, 8'hAA, 8'h0F, 8'hF0, 8'h50, 1'b0, 1'b0};
    vecs[7]  = '{3'd7, 8'hAA, 8'h0F, 8'hF0, 8'h5A, 1'b0, 1'b0};
    vecs[8]  = '{3'd3, 8'h01, 8'h00, 8'h00, 8'h01, 1'b0, 1'b1};
    vecs[9]  = '{3'd0, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[10] = '{3'd1, 8'hFF, 8'hFE, 8'h00, 8'h01, 1'b0, 1'b1};
    vecs[11] = '{3'd6, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0};
    vecs[12] = '{3'd7, 8'h12, 8'h13, 8'h00, 8'hFE, 1'b0, 1'b1};
    vecs[13] = '{3'd2, 8'h80, 8'h00, 8'h00, 8'h80, 1'b0, 1'b1};
    vecs[14] = '{3'd5, 8'h0F, 8'hF0, 8'hFF, 8'h0F, 1'b0, 1'b0};

    rst = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 3'd0, 8'h00, 8'h00, 8'h00);
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_y",         32'(y),         32'h00);
    chk("rst_zero",      32'(zero),      32'd0);
    chk("rst_parity",    32'(parity),    32'd0);
    chk("rst_txn",       32'(txn_count), 32'd0);
    $display("txn reset: out_valid=%0b y=%02h txn=%0d", out_valid, y, txn_count);

    // Single op: the result is visible on the cycle after the accept
    out_ready = 1'b1;
    drive(1'b1, 3'd0, 8'hF0, 8'h3C, 8'h00);
    step();
    drive(1'b0, 3'd0, 8'h00, 8'h00, 8'h00);
    chk("single_out_valid", 32'(out_valid), 32'd1);
    chk("single_y",         32'(y),         32'h30);
    chk("single_zero",      32'(zero),      32'd0);
    chk("single_parity",    32'(parity),    32'd0);
    chk("single_txn",       32'(txn_count), 32'd1);
    $display("txn single: y=%02h zero=%0b parity=%0b txn=%0d", y, zero, parity, txn_count);

    // Back-to-back table: with out_ready high the queue holds at count 1.
    // Each cycle checks one result and that in_ready stays high.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].s);
      chk("vec_in_ready", 32'(in_ready), 32'd1);
      step();
      chk("vec_out_valid", 32'(out_valid), 32'd1);
      chk("vec_y",         32'(y),         32'(vecs[i].y));
      chk("vec_zero",      32'(zero),      32'(vecs[i].z));
      chk("vec_parity",    32'(parity),    32'(vecs[i].p));
      chk("vec_txn",       32'(txn_count), 32'(i + 1));
      $display("txn vec %0d: op=%0d a=%02h b=%02h s=%02h -> y=%02h z=%0b p=%0b txn=%0d",
               i, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].s, y, zero, parity, txn_count);
    end
    drive(1'b0, 3'd0, 8'h00, 8'h00, 8'h00);
    step();
    chk("drain_out_valid", 32'(out_valid), 32'd0);

    // Back-pressure: two accepts fill the queue and a third is refused
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 3'd3, 8'h55, 8'h55, 8'h00);
    step();
    drive(1'b1, 3'd2, 8'h00, 8'h00, 8'h00);
    step();
    chk("bp_in_ready_full", 32'(in_ready),  32'd0);
    chk("bp_y_head",        32'(y),         32'h00);
    chk("bp_zero_head",     32'(zero),      32'd1);
    chk("bp_txn2",          32'(txn_count), 32'd2);
    drive(1'b1, 3'd0, 8'hFF, 8'hFF, 8'h00);  // would give FF if it were taken
    step();
    step();
    chk("bp_txn_hold",      32'(txn_count), 32'd2);
    chk("bp_in_ready_hold", 32'(in_ready),  32'd0);
    chk("bp_y_hold",        32'(y),         32'h00);
    $display("txn backpressure stall: in_ready=%0b y=%02h zero=%0b txn=%0d", in_ready, y, zero, txn_count);
    // Popping at count 2 cannot accept in the same cycle, so FF arrives one cycle later
    out_ready = 1'b1;
    step();
    chk("bp_pop1_valid", 32'(out_valid), 32'd1);
    chk("bp_pop1_y",     32'(y),         32'h00);
    chk("bp_pop1_zero",  32'(zero),      32'd1);
    chk("bp_pop1_txn",   32'(txn_count), 32'd2);
    chk("bp_pop1_ready", 32'(in_ready),  32'd1);
    step();
    drive(1'b0, 3'd0, 8'h00, 8'h00, 8'h00);
    chk("bp_pop2_y",     32'(y),         32'hFF);
    chk("bp_pop2_zero",  32'(zero),      32'd0);
    chk("bp_pop2_txn",   32'(txn_count), 32'd3);
    step();
    chk("bp_empty_valid", 32'(out_valid), 32'd0);
    chk("bp_empty_ready", 32'(in_ready),  32'd1);
    $display("txn backpressure drain: out_valid=%0b in_ready=%0b txn=%0d", out_valid, in_ready, txn_count);

    // Pop order at count 2, using distinct values
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 3'd0, 8'hF0, 8'h3C, 8'h00);   // 30
    step();
    drive(1'b1, 3'd3, 8'h01, 8'h00, 8'h00);   // 01
    step();
    drive(1'b0, 3'd0, 8'h00, 8'h00, 8'h00);
    chk("ord_head0", 32'(y), 32'h30);
    out_ready = 1'b1;
    step();
    chk("ord_head1",   32'(y),      32'h01);
    chk("ord_parity1", 32'(parity), 32'd1);
    out_ready = 1'b0;

    // Reset mid-operation: the queue is refilled to 2 and reset with traffic present
    drive(1'b1, 3'd2, 8'h0F, 8'hF0, 8'h00);   // FF
    step();
    chk("mr_full", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_out_valid", 32'(out_valid), 32'd0);
    chk("mr_y",         32'(y),         32'h00);
    chk("mr_zero",      32'(zero),      32'd0);
    chk("mr_parity",    32'(parity),    32'd0);
    chk("mr_txn",       32'(txn_count), 32'd0);
    chk("mr_in_ready",  32'(in_ready),  32'd1);
    // Reset again with the queue empty and in_valid high: no accept may register
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b0, 3'd0, 8'h00, 8'h00, 8'h00);
    chk("mr2_out_valid", 32'(out_valid), 32'd0);
    chk("mr2_txn",       32'(txn_count), 32'd0);
    step();
    chk("mr3_out_valid", 32'(out_valid), 32'd0);
    $display("txn midreset: out_valid=%0b y=%02h txn=%0d", out_valid, y, txn_count);

    // Counter wrap (CNT_W=4): 17 accepts, the last one a MUX with odd parity
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      if (k == 16) drive(1'b1, 3'd4, 8'h01, 8'hFF, 8'h00);
      else         drive(1'b1, 3'd3, 8'(k), 8'h00, 8'h00);
      step();
      if (k == 15) chk("wrap_txn16", 32'(txn_count), 32'd0);
    end
    drive(1'b0, 3'd0, 8'h00, 8'h00, 8'h00);
    chk("wrap_txn17",   32'(txn_count), 32'd1);
    chk("wrap_y",       32'(y),         32'h01);
    chk("wrap_parity",  32'(parity),    32'd1);
    chk("wrap_valid",   32'(out_valid), 32'd1);
    $display("txn wrap: y=%02h parity=%0b txn=%0d", y, parity, txn_count);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_cell_pipe.md
Name: logic_cell_pipe

Overview:
- Parametrised, registered successor to the single-bit 2-input logic cells (AND/NAND/OR/XOR/MUX).
- Performs one of eight bitwise operations on WIDTH-bit operands, selected per transaction. Computes zero and parity flags on the result.
- Buffers results in a 2-entry output queue with valid/ready handshakes on both sides.
- Used as the standard registered logic element in datapaths that need back-pressure. Simulation timescale is 1ns/10ps, matching the cell library.

Parameters:
- WIDTH, 8, operand and result width in bits (>=1).
- CNT_W, 16, width of the accepted-transaction counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set valid.
- in_ready  output  1  block can accept an operand set this cycle.
- op  input  3  operation select, sampled on accept.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- s  input  WIDTH  per-bit select (used by mux ops only).
- out_valid  output  1  head-of-queue result valid.
- out_ready  input  1  consumer accepts the head result.
- y  output  WIDTH  head result.
- zero  output  1  head result is all zeros.
- parity  output  1  XOR-reduction of the head result.
- txn_count  output  CNT_W  number of accepted operand sets, wraps modulo 2^CNT_W.

Behaviour:
- The clock and reset interface is fixed: one clock, clk; reset rst is synchronous and active-high.
- Op encoding (bitwise, per bit i):
  - 0 AND a&b
  - 1 NAND ~(a&b)
  - 2 OR a|b
  - 3 XOR a^b
  - 4 MUX s?b:a
  - 5 MUXI ~(s?b:a)
  - 6 NOR ~(a|b)
  - 7 XNOR ~(a^b)
- All ops are legal; no error path.
- Result, zero and parity are computed combinationally at accept time. They are stored together as one queue entry of WIDTH+2 bits.
- Accept occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- Queue:
  - 2 entries, count 0..2.
  - in_ready = (count != 2), derived from registered count only; no combinational path from out_ready.
  - out_valid = (count != 0).
  - y/zero/parity always reflect the head entry.
- Latency: an operand set accepted in cycle N is visible on y with out_valid=1 from cycle N+1 if the queue was empty. This gives full throughput of 1/cycle with out_ready held high.
- Count update per cycle:
  - accept only: +1
  - pop only: -1
  - accept and pop: unchanged; the head advances and the new entry is appended.
  - neither: unchanged.
- Boundaries:
  - count==2: in_ready=0; in_valid is ignored and a/b/s/op are not sampled.
  - count==0: out_valid=0; out_ready is ignored; y holds its last value, is not required to be zero, and must not be checked.
  - count==1 with simultaneous accept and pop: the new result becomes the head at the next edge and count stays 1.
  - count==2 with pop: count becomes 1 and the second entry becomes the head; no accept is possible that cycle.
- Upstream must hold in_valid and operands stable until accepted. Downstream sees y stable while out_valid=1 and out_ready=0.
- txn_count increments by 1 on every accept and wraps from 2^CNT_W-1 to 0.
- Reset (rst=1 at an edge, regardless of in-flight traffic):
  - count=0, out_valid=0, in_ready=1.
  - y=0, zero=0, parity=0, txn_count=0.
  - Queue pointers return to 0.
  - Any accept or pop in that same cycle is discarded.
  - in_ready may read 1 during reset cycles, but no accept is registered while rst=1.
- Width rules: all ops produce exactly WIDTH bits; zero = ~|y; parity = ^y.

Test Plan:
- Reset then single op (WIDTH=8): op=0, a=8'hF0, b=8'h3C, out_ready=1 -> next cycle out_valid=1, y=8'h30, zero=0, parity=0, txn_count=1.
- All ops sweep with a=8'hAA, b=8'h0F, s=8'hF0, back-to-back, out_ready=1:
  - y sequence: 0A, F5, AF, A5, 0A, F5, 50, 5A.
  - One result per cycle; in_ready never drops.
- Back-pressure: out_ready=0, issue op=3 a=b=8'h55 then op=2 a=8'h00 b=8'h00:
  - in_ready=0 after two accepts; y=00 with zero=1 held.
  - A third in_valid is not accepted and txn_count stays 2.
  - Raise out_ready: results pop in order, then in_ready returns to 1.
- Simultaneous push/pop at count==1: out_ready=1 with continuous in_valid -> count stays 1 and every result appears exactly once, in order.
- Reset mid-operation: fill the queue (count=2), assert rst for 1 cycle with in_valid=1 -> out_valid=0, y=0, txn_count=0, and no entry from that cycle appears afterward.
- Counter wrap with CNT_W=4: 17 accepts -> txn_count reads 1; parity check op=4 a=8'h01 b=8'hFF s=8'h00 -> y=01, parity=1.
